rf_mp: RTL
==========

Name: rf_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write/dual-read RF.
- Generalised in data width, register count, read-port count and write-port count.
- Adds a hardwired-zero register, optional write-to-read bypass, deterministic write-port priority, and a per-register busy scoreboard.
- Sits in decode/writeback: read ports feed operand fetch; write ports come from the writeback lanes.

Parameters:
- D_WIDTH, 32, data width in bits.
- N_REGS, 32, number of architectural registers (power of two, at least 2).
- REG_L2, $clog2(N_REGS), register address width.
- N_RD, 2, number of read ports (1..4).
- N_WR, 1, number of write ports (1..2).
- ZERO_R0, 1, when 1, register 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, when 1, reads return same-cycle write data (write-first).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  N_WR  per-lane write enable.
- w_addr  in  N_WR*REG_L2  per-lane write address; lane k occupies bits [k*REG_L2 +: REG_L2].
- w_data  in  N_WR*D_WIDTH  per-lane write data.
- rsv_en  in  1  reserve request: marks the destination register busy.
- rsv_addr  in  REG_L2  register to reserve.
- r_addr  in  N_RD*REG_L2  per-port read address.
- r_data  out  N_RD*D_WIDTH  per-port read data, combinational.
- r_busy  out  N_RD  per-port busy flag of the addressed register, combinational.

Behaviour:
- Reset: on a clk edge with rst=1, every register becomes 0 and every busy bit becomes 0. All writes and reservations in that cycle are ignored. From the next cycle, r_data=0 and r_busy=0 for every address.
- Write:
  - On a clk edge with rst=0, each lane with we[k]=1 stores w_data[k] into w_addr[k].
  - Latency: 1 cycle to the array.
- Write conflict: when two lanes have we=1 and the same address, the higher lane index wins. The array value and the bypass result must agree on the winner.
- Read:
  - r_data[p] = array[r_addr[p]], purely combinational, with no clock latency.
  - With BYPASS=1, if any lane writes r_addr[p] in the current cycle, return that lane's w_data instead, using the highest winning lane.
  - With BYPASS=0, the array value (the old value) is returned until the next cycle.
- Zero register: with ZERO_R0=1, a read of address 0 returns 0 (bypass included) and r_busy=0. Writes and rsv to address 0 have no effect.
- Scoreboard:
  - A busy bit per register.
  - rsv_en=1 sets busy[rsv_addr] at the edge.
  - A write on any lane clears busy[w_addr] at the edge.
  - If a reservation and a write hit the same address in the same cycle, the reservation wins and busy ends at 1 (a new producer supersedes the old one).
- r_busy:
  - r_busy[p] = busy[r_addr[p]].
  - With BYPASS=1, r_busy[p] is forced to 0 when a same-cycle write targets r_addr[p], so the consumer takes the bypassed data. This holds even if a same-cycle reservation re-sets the bit.
- Addressing: N_REGS is a power of two, so there is no out-of-range address.
- Reset mid-operation: rst dominates any concurrent we or rsv_en.

Decomposition:
- Shared package rf_pkg holds:
  - default constants RF_D_WIDTH=32 and RF_N_REGS=32;
  - an RF_LANE_PRIO note fixing "highest lane index wins";
  - a helper function for slicing packed per-port address fields.
- One natural sub-module, rf_scoreboard: busy-bit array, reservation/clear arbitration, and the per-port busy lookup.
- The data array and bypass muxes stay in rf_mp.

Test Plan:
1. Reset then read: assert rst for 1 cycle, then read r_addr={5,31} -> r_data={0,0}, r_busy={0,0}.
2. Write then read: we[0]=1, w_addr=3, w_data=0xDEADBEEF, with port 0 reading addr 3 in the same cycle.
   - BYPASS=1: same cycle -> r_data[0]=0xDEADBEEF.
   - BYPASS=0: same cycle -> old value 0; next cycle -> 0xDEADBEEF.
3. Write port priority (N_WR=2): lane0 writes 7<-0x11 and lane1 writes 7<-0x22 in the same cycle -> next cycle read of 7 returns 0x22; the same-cycle bypass also returns 0x22.
4. Zero register: we=1, w_addr=0, w_data=0xFFFF_FFFF and rsv_en=1, rsv_addr=0 -> next cycle read of 0 returns 0 with r_busy=0.
5. Scoreboard sequence, with port 0 reading addr 9 throughout:
   - rsv 9 at cycle t -> r_busy[0]=1 at t+1.
   - At t+2, drive both write of 9 <-0x5A and rsv 9 -> r_busy=0 in that cycle (bypass forcing, BYPASS=1) and r_busy=1 at t+3.
   - A plain write of 9 at t+4 -> r_busy=0 at t+5.
6. Reset mid-operation: after registers 1..4 are written and 2 is reserved, assert rst together with we=1 (w_addr=1, w_data=0x99) -> next cycle all registers read 0, including reg 1, and all busy bits are 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

   localparam int RF_D_WIDTH = 32;
   localparam int RF_N_REGS  = 32;

   // Write lanes resolve same-address conflicts with the highest lane index.
   localparam int RF_LANE_PRIO = 1;

   // Low bit of field idx in a packed vector made of width-bit fields.
   function automatic int field_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: reservation sets, writeback clears, and read ports look them up.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int N_REGS  = RF_N_REGS,
   parameter int REG_L2  = $clog2(N_REGS),
   parameter int N_RD    = 2,
   parameter int N_WR    = 1,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_WR-1:0]          we,
   input  logic [N_WR*REG_L2-1:0]   w_addr,
   input  logic                     rsv_en,
   input  logic [REG_L2-1:0]        rsv_addr,
   input  logic [N_RD*REG_L2-1:0]   r_addr,
   output logic [N_RD-1:0]          r_busy
);

   logic [N_REGS-1:0] busy;
   logic [N_REGS-1:0] busy_nxt;
   logic [REG_L2-1:0] wa [N_WR];
   logic [REG_L2-1:0] ra [N_RD];

   for (genvar k = 0; k < N_WR; k++) begin : g_wa
      assign wa[k] = w_addr[field_lo(k, REG_L2) +: REG_L2];
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_ra
      assign ra[p] = r_addr[field_lo(p, REG_L2) +: REG_L2];
   end

   // Reservation is applied after the clears so a new producer supersedes the old one.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < N_WR; k++) begin
         if (we[k]) busy_nxt[wa[k]] = 1'b0;
      end
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
      if (ZERO_R0 != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // A same-cycle write hides busy so the consumer takes the bypassed value.
   always_comb begin
      r_busy = '0;
      for (int p = 0; p < N_RD; p++) begin
         r_busy[p] = busy[ra[p]];
         for (int k = 0; k < N_WR; k++) begin
            if (BYPASS != 0 && we[k] && wa[k] == ra[p]) r_busy[p] = 1'b0;
         end
         if (ZERO_R0 != 0 && ra[p] == '0) r_busy[p] = 1'b0;
      end
   end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port register file with hardwired zero, write-first bypass and busy scoreboard.
module rf_mp
   import rf_pkg::*;
#(
   parameter int D_WIDTH = RF_D_WIDTH,
   parameter int N_REGS  = RF_N_REGS,
   parameter int REG_L2  = $clog2(N_REGS),
   parameter int N_RD    = 2,
   parameter int N_WR    = 1,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_WR-1:0]          we,
   input  logic [N_WR*REG_L2-1:0]   w_addr,
   input  logic [N_WR*D_WIDTH-1:0]  w_data,
   input  logic                     rsv_en,
   input  logic [REG_L2-1:0]        rsv_addr,
   input  logic [N_RD*REG_L2-1:0]   r_addr,
   output logic [N_RD*D_WIDTH-1:0]  r_data,
   output logic [N_RD-1:0]          r_busy
);

   logic [D_WIDTH-1:0] mem [N_REGS];
   logic [REG_L2-1:0]  wa  [N_WR];
   logic [D_WIDTH-1:0] wd  [N_WR];
   logic [REG_L2-1:0]  ra  [N_RD];

   for (genvar k = 0; k < N_WR; k++) begin : g_wr
      assign wa[k] = w_addr[field_lo(k, REG_L2) +: REG_L2];
      assign wd[k] = w_data[field_lo(k, D_WIDTH) +: D_WIDTH];
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      assign ra[p] = r_addr[field_lo(p, REG_L2) +: REG_L2];
   end

   // Lanes are visited in ascending order so the highest enabled lane lands last.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) mem[i] <= '0;
      end else begin
         for (int k = 0; k < N_WR; k++) begin
            if (we[k] && !(ZERO_R0 != 0 && wa[k] == '0)) mem[wa[k]] <= wd[k];
         end
      end
   end

   // Same ascending-lane override as the array, so bypass and storage agree on the winner.
   always_comb begin
      r_data = '0;
      for (int p = 0; p < N_RD; p++) begin
         r_data[field_lo(p, D_WIDTH) +: D_WIDTH] = mem[ra[p]];
         for (int k = 0; k < N_WR; k++) begin
            if (BYPASS != 0 && we[k] && wa[k] == ra[p])
               r_data[field_lo(p, D_WIDTH) +: D_WIDTH] = wd[k];
         end
         if (ZERO_R0 != 0 && ra[p] == '0) r_data[field_lo(p, D_WIDTH) +: D_WIDTH] = '0;
      end
   end

   rf_scoreboard #(
      .N_REGS  (N_REGS),
      .REG_L2  (REG_L2),
      .N_RD    (N_RD),
      .N_WR    (N_WR),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .w_addr   (w_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .r_addr   (r_addr),
      .r_busy   (r_busy)
   );

endmodule
